// File: rtl/tape_fsk_player.sv
// tape_fsk_player: plays cassette bytes arriving from the UART as an MC-10 FSK
// tape waveform. Bytes are queued in a small FIFO and sent LSB-first. A '0'
// bit is one 1200 Hz cycle and a '1' bit is one 2400 Hz cycle. Each cycle is
// a high half followed by a low half.
//
// Ports:
//   clk          system clock (clk_50 domain)
//   reset        asynchronous, active-high reset
//   rx_data      byte from the UART receiver
//   rx_ready     one-cycle strobe, rx_data valid in that cycle
//   enable       playback permitted
//   clr_overflow one-cycle strobe that clears the sticky overflow flag
//   tape_out     registered FSK tape level (to the TAPE_IN synchronizer)
//   busy         high while a byte is being played (state != IDLE)
//   fifo_full    FIFO holds DEPTH bytes
//   overflow     sticky, set when an incoming byte is dropped
//   fifo_count   number of bytes currently queued
module tape_fsk_player #(
    parameter int unsigned HALF_0 = 20833,
    parameter int unsigned HALF_1 = 10417,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               rx_data,
    input  logic                     rx_ready,
    input  logic                     enable,
    input  logic                     clr_overflow,
    output logic                     tape_out,
    output logic                     busy,
    output logic                     fifo_full,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = AW + 1;
    localparam int unsigned HMAX = (HALF_0 > HALF_1) ? HALF_0 : HALF_1;
    localparam int unsigned HCW  = $clog2(HMAX + 1);

    localparam logic [HCW-1:0] HC0  = HCW'(HALF_0 - 1);
    localparam logic [HCW-1:0] HC1  = HCW'(HALF_1 - 1);
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [7:0]    head_c;

    logic          push_c;
    logic          drop_c;
    logic          can_pop_c;
    logic          pop_c;

    // ------------------------------------------------------------------
    // Player registers
    // ------------------------------------------------------------------
    state_t         state;
    state_t         state_d;
    logic [7:0]     sr;
    logic [7:0]     sr_d;
    logic [2:0]     bi;
    logic [2:0]     bi_d;
    logic [HCW-1:0] hc;
    logic [HCW-1:0] hc_d;
    logic           tape_d;

    // Full-FIFO writes are dropped outright; a same-cycle pop does not make room.
    assign push_c    = rx_ready && (count != FULL);
    assign drop_c    = rx_ready && (count == FULL);
    assign can_pop_c = enable && (count != '0);
    assign head_c    = mem[rd_ptr];

    // Half-period reload value for a given bit.
    function automatic logic [HCW-1:0] half_for(input logic b);
        return b ? HC1 : HC0;
    endfunction

    // Next-state and datapath decode for the bit serializer.
    always_comb begin
        state_d = state;
        sr_d    = sr;
        bi_d    = bi;
        hc_d    = hc;
        pop_c   = 1'b0;

        unique case (state)
            IDLE: begin
                if (can_pop_c) begin
                    pop_c   = 1'b1;
                    sr_d    = head_c;
                    bi_d    = 3'd0;
                    hc_d    = half_for(head_c[0]);
                    state_d = HIGH;
                end
            end

            HIGH: begin
                if (hc == '0) begin
                    hc_d    = half_for(sr[0]);
                    state_d = LOW;
                end else begin
                    hc_d = hc - HCW'(1);
                end
            end

            LOW: begin
                if (hc == '0) begin
                    if (bi != 3'd7) begin
                        sr_d    = {1'b0, sr[7:1]};
                        bi_d    = bi + 3'd1;
                        hc_d    = half_for(sr[1]);
                        state_d = HIGH;
                    end else if (can_pop_c) begin
                        // Chain straight into the next byte with no idle cycle.
                        pop_c   = 1'b1;
                        sr_d    = head_c;
                        bi_d    = 3'd0;
                        hc_d    = half_for(head_c[0]);
                        state_d = HIGH;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    hc_d = hc - HCW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        tape_d = (state_d == HIGH);
    end

    // Player state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            sr       <= '0;
            bi       <= '0;
            hc       <= '0;
            tape_out <= 1'b0;
        end else begin
            state    <= state_d;
            sr       <= sr_d;
            bi       <= bi_d;
            hc       <= hc_d;
            tape_out <= tape_d;
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            unique case ({push_c, pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // A drop in the same cycle as a clear keeps the flag set.
            if (drop_c) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    // FIFO data array; contents need no reset because count gates all reads.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    assign fifo_count = count;
    assign fifo_full  = (count == FULL);
    assign busy       = (state != IDLE);

endmodule

// File: doc/tape_fsk_player.md
Name: tape_fsk_player

Overview:
- Streams cassette images received over the UART into the computer as an MC-10 FSK tape waveform.
- Sits directly upstream of the top level's TAPE_IN synchronizer.
- Accepts bytes from the UART receive strobe into a small FIFO.
- Serializes each byte LSB-first: one 1200 Hz cycle per '0' bit, one 2400 Hz cycle per '1' bit.
- Drives the result as a single-bit tape level for the CPU's port B bit 7.

Parameters:
- HALF_0, 20833, clock cycles per half-period of a '0' bit (1200 Hz at 50 MHz).
- HALF_1, 10417, clock cycles per half-period of a '1' bit (2400 Hz at 50 MHz).
- DEPTH, 16, FIFO depth in bytes (power of two, >= 2).

Ports:
- clk, input, 1: system clock (clk_50 domain).
- reset, input, 1: asynchronous, active-high reset.
- rx_data, input, 8: byte from UART receiver.
- rx_ready, input, 1: one-cycle strobe; rx_data is valid in that cycle.
- enable, input, 1: playback permitted.
- clr_overflow, input, 1: one-cycle strobe that clears the overflow flag.
- tape_out, output, 1: FSK tape level, registered.
- busy, output, 1: high while not in IDLE.
- fifo_full, output, 1: count == DEPTH.
- overflow, output, 1: sticky; set when a byte is dropped.
- fifo_count, output, $clog2(DEPTH)+1: bytes currently queued.

Behaviour:
- Reset (async, active-high) forces these values; FIFO pointers are also cleared:
  - tape_out=0, busy=0, fifo_full=0, overflow=0, fifo_count=0, state=IDLE.
- Push: on rx_ready with pre-cycle count < DEPTH, write rx_data at the write pointer; count increments next cycle.
- Dropped push: on rx_ready with pre-cycle count == DEPTH, the byte is dropped and overflow is set. No bypass, even if a pop occurs in the same cycle.
- Simultaneous push and pop with count < DEPTH: both take effect; count is unchanged.
- Pop on empty never occurs.
- clr_overflow clears overflow. If it coincides with a drop, set wins.
- States are IDLE, HIGH and LOW. Registers: shift reg sr[7:0], bit index bi[2:0], half-period counter hc.
- IDLE:
  - tape_out=0.
  - If enable && count>0: pop into sr, bi=0, hc=(sr bit0 ? HALF_1 : HALF_0)-1, go to HIGH.
- HIGH:
  - tape_out=1; hc decrements each cycle.
  - At hc==0: reload hc with the same half-period minus 1, go to LOW.
- LOW:
  - tape_out=0; hc decrements each cycle.
  - At hc==0 with bi<7: shift sr right, bi++, load hc for the new bit0, go to HIGH.
  - At hc==0 with bi==7 and enable && count>0: pop the next byte and go directly to HIGH (no gap cycle).
  - At hc==0 with bi==7 otherwise: go to IDLE.
- Each half-phase lasts exactly HALF_x cycles. A '0' bit totals 2*HALF_0 cycles; a '1' bit totals 2*HALF_1 cycles.
- Latency: with rx_ready at cycle t, IDLE, enable=1 and an empty FIFO:
  - count=1 at t+1, pop at t+1, tape_out rises at t+2.
- Deasserting enable mid-byte lets the current byte finish, then the block returns to IDLE. Queued bytes are retained.
- busy = (state != IDLE).
- fifo_full is combinational from count.
- Pointers wrap modulo DEPTH.

Test Plan:
(Bench parameters: HALF_0=8, HALF_1=4, DEPTH=4.)
- Single byte: enable=1, push 0xA5 -> tape_out bit durations for bits 1,0,1,0,0,1,0,1 are 4H/4L or 8H/8L; 96 cycles total; busy falls on the following cycle; tape_out first rises 2 cycles after the strobe.
- Back-to-back: push 0x00 then 0xFF while playing -> no gap between bytes; 128 cycles for 0x00, then 64 cycles for 0xFF; fifo_count returns to 0.
- Overflow: enable=0, push 5 bytes -> fifo_full=1, fifo_count=4, overflow=1, 5th byte absent on playback. Then pulse clr_overflow -> overflow=0.
- Enable drop: deassert enable during bit 3 of the first of two queued bytes -> first byte completes, IDLE, fifo_count=1. Re-enable -> second byte plays.
- Reset mid-byte: assert reset during a HIGH phase -> tape_out=0, busy=0 and fifo_count=0 immediately (asynchronous), with no further output after release.
- Pointer wrap: push/play 10 bytes 0x01..0x0A with DEPTH=4 -> decoded bit stream matches order exactly.
